// File: rtl/dmem_access_ctrl_if.sv
// Data-memory req/ack bus between the access sequencer (master) and memory (slave).
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle load/store sequencer: turns decoded load/store codes into one or two
// word-aligned req/ack bus transactions, stalls the core meanwhile and returns the
// extended load data on a one-cycle done pulse.
module dmem_access_ctrl #(
    parameter int SPLIT_MISALIGNED = 1,
    parameter int TIMEOUT          = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                load_ctrl,
    input  logic [1:0]                store_ctrl,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    output logic                      stall,
    output logic                      done,
    output logic                      err,
    output logic [31:0]               rdata,
    dmem_access_ctrl_if.master        bus
);

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        gap_q, gap_d;

    logic        is_st_q, is_st_d;
    logic [2:0]  ld_ctrl_q, ld_ctrl_d;
    logic [1:0]  off_q, off_d;
    logic        cross_q, cross_d;
    logic [7:0]  be8_q, be8_d;
    logic [63:0] wd64_q, wd64_d;
    logic [29:0] base_q, base_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;

    logic        is_ld, is_st, op, illegal, cross_in, bad_in, timeout_hit;
    logic [1:0]  size_in;
    logic [3:0]  mask_in;
    logic [7:0]  be8_in;
    logic [63:0] wd64_in;
    logic [31:0] v;

    // Decode the incoming request and compute lane placement for both words
    always_comb begin
        is_ld    = (load_ctrl != 3'b111);
        is_st    = (store_ctrl != 2'b11);
        op       = is_ld || is_st;
        illegal  = (is_ld && (load_ctrl == 3'b011 || load_ctrl == 3'b110)) || (is_ld && is_st);
        size_in  = is_ld ? load_ctrl[1:0] : store_ctrl;
        case (size_in)
            2'b00:   mask_in = 4'b0001;
            2'b01:   mask_in = 4'b0011;
            default: mask_in = 4'b1111;
        endcase
        be8_in   = {4'b0000, mask_in} << addr[1:0];
        wd64_in  = {32'h0, wdata} << {addr[1:0], 3'b000};
        cross_in = (be8_in[7:4] != 4'b0000);
        bad_in   = illegal || (cross_in && SPLIT_MISALIGNED == 0);
        // An ack arriving on the limit cycle still counts as a normal completion
        timeout_hit = (TIMEOUT > 0) && !bus.mem_ack && (cnt_q == 32'(TIMEOUT - 1));
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            gap_q   <= gap_d;
        end
    end

    // Latched request attributes and captured read words (no reset needed)
    always_ff @(posedge clk) begin
        is_st_q   <= is_st_d;
        ld_ctrl_q <= ld_ctrl_d;
        off_q     <= off_d;
        cross_q   <= cross_d;
        be8_q     <= be8_d;
        wd64_q    <= wd64_d;
        base_q    <= base_d;
        lo_q      <= lo_d;
        hi_q      <= hi_d;
    end

    // Next-state, timeout counting and data capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        gap_d     = 1'b0;
        is_st_d   = is_st_q;
        ld_ctrl_d = ld_ctrl_q;
        off_d     = off_q;
        cross_d   = cross_q;
        be8_d     = be8_q;
        wd64_d    = wd64_q;
        base_d    = base_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        case (state_q)
            S_IDLE: begin
                if (op) begin
                    is_st_d   = is_st;
                    ld_ctrl_d = load_ctrl;
                    off_d     = addr[1:0];
                    cross_d   = cross_in;
                    be8_d     = be8_in;
                    wd64_d    = wd64_in;
                    base_d    = addr[31:2];
                    err_d     = bad_in;
                    cnt_d     = '0;
                    state_d   = bad_in ? S_DONE : S_ACC0;
                end
            end
            S_ACC0: begin
                if (bus.mem_ack) begin
                    lo_d  = bus.mem_rdata;
                    cnt_d = '0;
                    if (cross_q) begin
                        state_d = S_ACC1;
                        gap_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_ACC1: begin
                // First ACC1 cycle keeps mem_req low so the bus sees a gap
                if (!gap_q) begin
                    if (bus.mem_ack) begin
                        hi_d    = bus.mem_rdata;
                        state_d = S_DONE;
                    end else if (timeout_hit) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: bus drive per state, load extension on the done cycle
    always_comb begin
        stall         = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        rdata         = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        v             = 32'({hi_q, lo_q} >> {off_q, 3'b000});
        case (state_q)
            S_IDLE: stall = op;
            S_ACC0: begin
                stall         = 1'b1;
                bus.mem_req   = 1'b1;
                bus.mem_we    = is_st_q;
                bus.mem_addr  = {base_q, 2'b00};
                bus.mem_be    = be8_q[3:0];
                bus.mem_wdata = wd64_q[31:0];
            end
            S_ACC1: begin
                stall         = 1'b1;
                bus.mem_req   = !gap_q;
                bus.mem_we    = is_st_q && !gap_q;
                bus.mem_addr  = {base_q + 30'd1, 2'b00};
                bus.mem_be    = be8_q[7:4];
                bus.mem_wdata = wd64_q[63:32];
            end
            S_DONE: begin
                done = 1'b1;
                err  = err_q;
                if (!err_q && !is_st_q) begin
                    case (ld_ctrl_q)
                        3'b000:  rdata = {{24{v[7]}}, v[7:0]};
                        3'b001:  rdata = {{16{v[15]}}, v[15:0]};
                        3'b100:  rdata = {24'h0, v[7:0]};
                        3'b101:  rdata = {16'h0, v[15:0]};
                        default: rdata = v;
                    endcase
                end
            end
            default: stall = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: vector table with a small reactive memory,
// plus hand-written sequences for misalign-error and mid-access reset.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  load_ctrl;
    logic [1:0]  store_ctrl;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;

    logic [2:0]  ns_load_ctrl;
    logic [1:0]  ns_store_ctrl;
    logic [31:0] ns_addr, ns_wdata;
    logic        ns_stall, ns_done, ns_err;
    logic [31:0] ns_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl_if bus();
    dmem_access_ctrl_if bus_ns();

    dmem_access_ctrl #(.SPLIT_MISALIGNED(1), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .load_ctrl(load_ctrl), .store_ctrl(store_ctrl),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .err(err),
        .rdata(rdata), .bus(bus.master)
    );

    dmem_access_ctrl #(.SPLIT_MISALIGNED(0), .TIMEOUT(4)) dut_ns (
        .clk(clk), .rst(rst), .load_ctrl(ns_load_ctrl), .store_ctrl(ns_store_ctrl),
        .addr(ns_addr), .wdata(ns_wdata), .stall(ns_stall), .done(ns_done), .err(ns_err),
        .rdata(ns_rdata), .bus(bus_ns.master)
    );

    typedef struct {
        string       name;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_err;
        int          exp_ntx;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic        we;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] exp_rd;
        int          dcyc;
        int          reqcyc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          ntx, waited, reqc, dcyc, ctrl_bad, gap_bad;
        logic        ackp, seen, er;
        logic [31:0] rd;
        logic [31:0] ta[2];
        logic [3:0]  tbe[2];
        logic        tw[2];
        logic [31:0] td[2];
        ntx = 0; waited = 0; reqc = 0; dcyc = -1; ctrl_bad = 0; gap_bad = 0;
        seen = 1'b0; er = 1'b0; rd = '0;
        for (int i = 0; i < 2; i++) begin
            ta[i] = '0; tbe[i] = '0; tw[i] = 1'b0; td[i] = '0;
        end
        load_ctrl  = v.ld;
        store_ctrl = v.st;
        addr       = v.addr;
        wdata      = v.wdata;
        #1;
        chk({v.name, " stall_on_op"}, 32'(stall), 32'd1);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            ackp = bus.mem_ack;
            bus.mem_ack = 1'b0;
            if (ackp && bus.mem_req) gap_bad++;
            if (bus.mem_req) reqc++;
            if (done) begin
                seen = 1'b1;
                dcyc = c;
                rd   = rdata;
                er   = err;
                if (stall) ctrl_bad++;
                load_ctrl  = 3'b111;
                store_ctrl = 2'b11;
            end else begin
                if (!stall || err) ctrl_bad++;
            end
            if (bus.mem_req && !ackp) begin
                if (waited == v.lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = (bus.mem_addr == v.a0) ? v.w0 : v.w1;
                    if (ntx < 2) begin
                        ta[ntx]  = bus.mem_addr;
                        tbe[ntx] = bus.mem_be;
                        tw[ntx]  = bus.mem_we;
                        td[ntx]  = bus.mem_wdata;
                    end
                    ntx++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end
        end
        if (!seen) begin
            load_ctrl  = 3'b111;
            store_ctrl = 2'b11;
        end
        chk({v.name, " done_seen"}, 32'(seen), 32'd1);
        chk({v.name, " done_cycle"}, 32'(dcyc), 32'(v.dcyc));
        chk({v.name, " req_cycles"}, 32'(reqc), 32'(v.reqcyc));
        chk({v.name, " ntx"}, 32'(ntx), 32'(v.exp_ntx));
        chk({v.name, " err"}, 32'(er), 32'(v.exp_err));
        chk({v.name, " rdata"}, rd, v.exp_rd);
        chk({v.name, " stall_err_during"}, 32'(ctrl_bad), 32'd0);
        chk({v.name, " req_gap"}, 32'(gap_bad), 32'd0);
        if (v.exp_ntx >= 1) begin
            chk({v.name, " tx0_addr"}, ta[0], v.a0);
            chk({v.name, " tx0_be"}, 32'(tbe[0]), 32'(v.be0));
            chk({v.name, " tx0_we"}, 32'(tw[0]), 32'(v.we));
            if (v.we) chk({v.name, " tx0_wdata"}, td[0], v.wd0);
        end
        if (v.exp_ntx >= 2) begin
            chk({v.name, " tx1_addr"}, ta[1], v.a1);
            chk({v.name, " tx1_be"}, 32'(tbe[1]), 32'(v.be1));
            chk({v.name, " tx1_we"}, 32'(tw[1]), 32'(v.we));
            if (v.we) chk({v.name, " tx1_wdata"}, td[1], v.wd1);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk({v.name, " done_single_pulse"}, 32'(done), 32'd0);
        chk({v.name, " idle_after"}, {30'd0, stall, bus.mem_req}, 32'd0);
    endtask

    initial begin
        //           name          ld      st     addr          wdata         lat w0            w1            err ntx a0            be0      we    wd0           a1            be1      wd1           rd            dcyc req
        vecs[0]  = '{"lw_aligned", 3'b010, 2'b11, 32'h00000100, 32'h0,        2,  32'hDEADBEEF, 32'h0,        1'b0, 1, 32'h00000100, 4'b1111, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hDEADBEEF, 3, 3};
        vecs[1]  = '{"sb_lane2",   3'b111, 2'b00, 32'h00000102, 32'h000000A5, 0,  32'h0,        32'h0,        1'b0, 1, 32'h00000100, 4'b0100, 1'b1, 32'h00A50000, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1};
        vecs[2]  = '{"lh_split",   3'b001, 2'b11, 32'h00000103, 32'h0,        1,  32'h80123456, 32'h123456FF, 1'b0, 2, 32'h00000100, 4'b1000, 1'b0, 32'h0,        32'h00000104, 4'b0001, 32'h0,        32'hFFFFFF80, 5, 4};
        vecs[3]  = '{"lhu_split",  3'b101, 2'b11, 32'h00000103, 32'h0,        1,  32'h80123456, 32'h123456FF, 1'b0, 2, 32'h00000100, 4'b1000, 1'b0, 32'h0,        32'h00000104, 4'b0001, 32'h0,        32'h0000FF80, 5, 4};
        vecs[4]  = '{"lb_sext",    3'b000, 2'b11, 32'h00000101, 32'h0,        0,  32'h1234F600, 32'h0,        1'b0, 1, 32'h00000100, 4'b0010, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hFFFFFFF6, 1, 1};
        vecs[5]  = '{"lbu_lane3",  3'b100, 2'b11, 32'h00000203, 32'h0,        0,  32'hC3000000, 32'h0,        1'b0, 1, 32'h00000200, 4'b1000, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h000000C3, 1, 1};
        vecs[6]  = '{"sw_split",   3'b111, 2'b10, 32'h000000FE, 32'h11223344, 0,  32'h0,        32'h0,        1'b0, 2, 32'h000000FC, 4'b1100, 1'b1, 32'h33440000, 32'h00000100, 4'b0011, 32'h00001122, 32'h0,        3, 2};
        vecs[7]  = '{"sh_upper",   3'b111, 2'b01, 32'h00000102, 32'hFFFFBEEF, 0,  32'h0,        32'h0,        1'b0, 1, 32'h00000100, 4'b1100, 1'b1, 32'hBEEF0000, 32'h0,        4'b0000, 32'h0,        32'h0,        1, 1};
        vecs[8]  = '{"ld_illegal", 3'b011, 2'b11, 32'h00000100, 32'h0,        0,  32'h0,        32'h0,        1'b1, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        0, 0};
        vecs[9]  = '{"ld_and_st",  3'b010, 2'b10, 32'h00000100, 32'h0,        0,  32'h0,        32'h0,        1'b1, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        0, 0};
        vecs[10] = '{"lw_timeout", 3'b010, 2'b11, 32'h00000100, 32'h0,        99, 32'h12345678, 32'h0,        1'b1, 0, 32'h0,        4'b0000, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        4, 4};
        vecs[11] = '{"lw_ack_lim", 3'b010, 2'b11, 32'h00000300, 32'h0,        3,  32'hCAFEF00D, 32'h0,        1'b0, 1, 32'h00000300, 4'b1111, 1'b0, 32'h0,        32'h0,        4'b0000, 32'h0,        32'hCAFEF00D, 4, 4};
        vecs[12] = '{"lw_wrap",    3'b010, 2'b11, 32'hFFFFFFFD, 32'h0,        0,  32'h33221100, 32'h00000044, 1'b0, 2, 32'hFFFFFFFC, 4'b1110, 1'b0, 32'h0,        32'h00000000, 4'b0001, 32'h0,        32'h44332211, 3, 2};

        rst = 1'b1;
        load_ctrl = 3'b111; store_ctrl = 2'b11; addr = '0; wdata = '0;
        ns_load_ctrl = 3'b111; ns_store_ctrl = 2'b11; ns_addr = '0; ns_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        bus_ns.mem_ack = 1'b0; bus_ns.mem_rdata = '0;
        repeat (2) @(negedge clk);

        chk("rst_ctrl", {28'd0, stall, done, err, bus.mem_req}, 32'd0);
        chk("rst_we_be", {27'd0, bus.mem_we, bus.mem_be}, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        chk("rst_wdata", bus.mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ns_ctrl", {28'd0, ns_stall, ns_done, ns_err, bus_ns.mem_req}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Misaligned store with splitting disabled: error without touching the bus
        ns_store_ctrl = 2'b10; ns_addr = 32'h00000101; ns_wdata = 32'h01020304;
        #1;
        chk("ns_stall_on_op", 32'(ns_stall), 32'd1);
        @(negedge clk);
        chk("ns_done", 32'(ns_done), 32'd1);
        chk("ns_err", 32'(ns_err), 32'd1);
        chk("ns_no_req", 32'(bus_ns.mem_req), 32'd0);
        chk("ns_rdata", ns_rdata, 32'd0);
        ns_store_ctrl = 2'b11;
        @(negedge clk);
        chk("ns_done_pulse", {30'd0, ns_done, bus_ns.mem_req}, 32'd0);

        // Reset while the second half of a split load is on the bus
        load_ctrl = 3'b001; addr = 32'h00000103;
        @(negedge clk);
        chk("rstmid_acc0_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80000000;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("rstmid_acc1_req", 32'(bus.mem_req), 32'd1);
        chk("rstmid_acc1_addr", bus.mem_addr, 32'h00000104);
        rst = 1'b1; load_ctrl = 3'b111;
        @(negedge clk);
        chk("rstmid_req_drop", 32'(bus.mem_req), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_done_err", {30'd0, done, err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_vec('{"lw_after_rst", 3'b010, 2'b11, 32'h00000200, 32'h0, 1, 32'h55AA55AA, 32'h0, 1'b0, 1,
                  32'h00000200, 4'b1111, 1'b0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h55AA55AA, 2, 2});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Multi-cycle data-memory sequencer between the core's load/store control outputs and a req/ack data-memory bus. It takes the decoded load/store control codes, address and store data, and generates word-aligned bus transactions with byte enables. Accesses that cross a 32-bit word boundary are split into two transactions. It stalls the core until the access completes and returns the extended load data for writeback.

Parameters:
SPLIT_MISALIGNED, 1, 1 = split word-crossing accesses into two bus transactions; 0 = flag them as errors with no bus access
TIMEOUT, 64, max cycles to wait for mem_ack per transaction; 0 = wait forever

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
load_ctrl  input  3  funct3 of load (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU); 111 = no load
store_ctrl  input  2  funct3[1:0] of store (00 SB, 01 SH, 10 SW); 11 = no store
addr  input  32  byte address (ALU result)
wdata  input  32  store data (rs2), right-aligned
stall  output  1  hold the core's PC and pipeline
done  output  1  one-cycle pulse: access finished
err  output  1  one-cycle pulse with done: illegal code, misalign with SPLIT_MISALIGNED=0, or timeout
rdata  output  32  extended load result; valid while done=1
mem_req  output  1  bus request
mem_we  output  1  1 = write
mem_addr  output  32  word-aligned address; [1:0]=00
mem_be  output  4  byte enables
mem_wdata  output  32  lane-aligned write data
mem_rdata  input  32  read word; valid when mem_ack=1
mem_ack  input  1  transaction complete

Behaviour:
- Reset: state IDLE. stall, done, err, mem_req, mem_we=0. mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, and the timeout counter=0.
- Operation valid (op) when load_ctrl!=111 or store_ctrl!=11.
- Illegal: load_ctrl in {011,110}, or load and store both valid.
- Lane math: off=addr[1:0], mask=0001/0011/1111 for B/H/W. be8=mask<<off (8 bits). wd64={32'b0,wdata}<<(8*off). Word0 uses be8[3:0] and wd64[31:0]. Word1 uses be8[7:4] and wd64[63:32]. cross = (be8[7:4]!=0).
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - stall = op (combinational).
  - On op: latch type, off, mask, and base={addr[31:2],2'b00}.
  - If illegal, or cross with SPLIT_MISALIGNED=0: go to DONE with err, no bus access.
  - Otherwise go to ACC0.
- ACC0:
  - mem_req=1, mem_addr=base, mem_be=word0 enables, mem_we=store. Address, enables and write data stay stable until ack.
  - stall=1.
  - On ack: capture mem_rdata into lo. If cross, go to ACC1; else go to DONE.
  - The next transaction's request starts the cycle after ack, so mem_req drops for at least one cycle between transactions.
- ACC1: same as ACC0 with mem_addr=base+4 (32-bit wrap) and word1 enables. On ack: capture hi, go to DONE.
- DONE:
  - One cycle. done=1, stall=0, mem_req=0. Go to IDLE.
  - The core advances on this edge. An op seen in the following IDLE cycle is a new instruction.
- Load result: v=({hi,lo}>>(8*off)).
  - LB/LH: sign-extend v[7:0]/v[15:0].
  - LBU/LHU: zero-extend.
  - LW: v[31:0].
  - rdata=0 for stores and errors.
- Timeout (TIMEOUT>0):
  - The counter clears on entering ACC0/ACC1 and increments each cycle without ack.
  - When it reaches TIMEOUT with no ack, drop mem_req and go to DONE with err=1 and rdata=0.
  - An ack in the same cycle as the limit wins: normal completion, no err.
- A store that errors on its second transaction leaves word0 written; there is no rollback.
- Reset mid-access: the state returns to IDLE at the next edge and mem_req drops. The memory must tolerate an abandoned request.
- mem_ack outside ACC0/ACC1 is ignored.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ack 2 cycles after req -> mem_addr=0x100, be=1111, we=0. stall is high until DONE, done pulses once, rdata=0xDEADBEEF. Total 5 cycles from op to done.
- SB addr=0x102, wdata=0x000000A5 -> mem_addr=0x100, be=0100, mem_wdata[23:16]=0xA5, we=1, done with rdata=0.
- LH addr=0x103 (SPLIT_MISALIGNED=1), word 0x100=0x80xxxxxx, word 0x104=0xxxxxxxFF -> two requests (0x100 be=1000, then 0x104 be=0001), rdata=0xFFFFFF80. The LHU variant gives rdata=0x0000FF80.
- SW addr=0x101 with SPLIT_MISALIGNED=0 -> no mem_req, done+err after 1 cycle. load_ctrl=011 -> same err, no bus access.
- LW with mem_ack held low, TIMEOUT=4 -> mem_req high for 4 cycles then drops, done+err, rdata=0. A repeat with ack on the 4th cycle -> normal done, err=0.
- rst asserted during ACC1 of a split access -> next cycle mem_req=0, stall=0, state IDLE. A following LW at 0x200 completes normally.
